// File: rtl/wbr_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// wbr_ctrl -- IEEE 1500 wrapper serial control sequencer with WIR.
//
// Purpose:
//   Holds the Wrapper Instruction Register, decodes the active instruction into
//   WBR mode controls and generates WBR capture/shift/update enables, either as
//   registered copies of the serial WSC strobes or from an internal auto-scan
//   engine when WP_EXTEST is active.
//
// Optional feature (compile-time macro WBR_CTRL_SAFE_RESET_EN):
//   defined   -> wir_q resets to WS_SAFE (011) and wbr_mode/wse_outputs/
//                hold_outputs are 1 from the first cycle after reset.
//   undefined -> wir_q resets to WS_BYPASS (000), all mode outputs 0.
//
// Ports:
//   CLK, reset          clock, synchronous active-high reset
//   WSI, WSO            serial data in / out
//   SelectWIR           1 = WSC targets the WIR, 0 = the selected WR
//   CaptureWR/ShiftWR/UpdateWR  WSC strobes
//   wbr_so              serial out of the WBR chain
//   run_req             auto-scan start pulse (WP_EXTEST only)
//   wir_q               active instruction (raw value)
//   wse_outputs, hold_outputs, wbr_mode   WBR mode controls (registered decode)
//   wbr_capture, wbr_shift, wbr_update    WBR enables
//   busy, done          auto-scan in progress / 1-cycle end pulse
//   protocol_err        1-cycle pulse on an illegal strobe combination
//   scan_state          auto-scan FSM state (debug)
//
// Strobe protocol: a strobe is accepted only when exactly one of
// CaptureWR/ShiftWR/UpdateWR is high and busy is low. Two or more strobes in a
// cycle, or any strobe while busy, does nothing and pulses protocol_err in the
// following cycle. There is no back-pressure; strobes are never stalled.
// -----------------------------------------------------------------------------
module wbr_ctrl #(
  parameter int WIR_WIDTH = 3,
  parameter int WBR_LEN   = 21,
  parameter int CNT_W     = 5
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 WSI,
  input  logic                 SelectWIR,
  input  logic                 CaptureWR,
  input  logic                 ShiftWR,
  input  logic                 UpdateWR,
  input  logic                 wbr_so,
  input  logic                 run_req,
  output logic                 WSO,
  output logic [WIR_WIDTH-1:0] wir_q,
  output logic                 wse_outputs,
  output logic                 hold_outputs,
  output logic                 wbr_mode,
  output logic                 wbr_capture,
  output logic                 wbr_shift,
  output logic                 wbr_update,
  output logic                 busy,
  output logic                 done,
  output logic                 protocol_err,
  output logic [2:0]           scan_state
);

  localparam logic [WIR_WIDTH-1:0] I_EXTEST    = WIR_WIDTH'(1);
  localparam logic [WIR_WIDTH-1:0] I_INTEST    = WIR_WIDTH'(2);
  localparam logic [WIR_WIDTH-1:0] I_SAFE      = WIR_WIDTH'(3);
  localparam logic [WIR_WIDTH-1:0] I_WP_EXTEST = WIR_WIDTH'(4);

`ifdef WBR_CTRL_SAFE_RESET_EN
  localparam logic [WIR_WIDTH-1:0] RST_WIR  = I_SAFE;
  localparam logic                 RST_MODE = 1'b1;
`else
  localparam logic [WIR_WIDTH-1:0] RST_WIR  = '0;
  localparam logic                 RST_MODE = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SHIFT   = 3'd1,
    S_UPDATE  = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               fsm_shift, fsm_update, fsm_capture;

  logic [WIR_WIDTH-1:0] wir_stage;
  logic                 bypass_q;
  logic                 ser_capture, ser_shift, ser_update;
  logic                 is_safe_q, is_ext_q;

  // ---------------------------------------------------------------------------
  // Instruction decode of the current WIR (unregistered; used for routing).
  // Unused codes above WP_EXTEST behave as WS_BYPASS.
  // ---------------------------------------------------------------------------
  logic is_wp, is_std, is_bypass;
  assign is_wp     = (wir_q == I_WP_EXTEST);
  assign is_std    = (wir_q == I_EXTEST) || (wir_q == I_INTEST) || (wir_q == I_SAFE);
  assign is_bypass = !is_wp && !is_std;

  // ---------------------------------------------------------------------------
  // Strobe qualification
  // ---------------------------------------------------------------------------
  logic [1:0] n_strobes;
  logic       any_strobe, multi_strobe, strobe_ok;
  logic       cap_ok, shift_ok, upd_ok;

  assign n_strobes    = 2'(CaptureWR) + 2'(ShiftWR) + 2'(UpdateWR);
  assign any_strobe   = (n_strobes != 2'd0);
  assign multi_strobe = (n_strobes > 2'd1);
  assign strobe_ok    = any_strobe && !multi_strobe && !busy;
  assign cap_ok       = strobe_ok && CaptureWR;
  assign shift_ok     = strobe_ok && ShiftWR;
  assign upd_ok       = strobe_ok && UpdateWR;

  // ---------------------------------------------------------------------------
  // Auto-scan FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Auto-scan FSM: next state. The counter is loaded with WBR_LEN-1 so that
  // SHIFT lasts exactly WBR_LEN cycles (it leaves on the cycle cnt reads 0).
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      S_IDLE: begin
        if (run_req && is_wp) begin
          state_n = S_SHIFT;
          cnt_n   = CNT_W'(WBR_LEN - 1);
        end
      end
      S_SHIFT: begin
        if (cnt == '0) state_n = S_UPDATE;
        else           cnt_n   = cnt - CNT_W'(1);
      end
      S_UPDATE:  state_n = S_CAPTURE;
      S_CAPTURE: state_n = S_DONE;
      S_DONE:    state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  // Auto-scan FSM: outputs
  always_comb begin
    fsm_shift   = 1'b0;
    fsm_update  = 1'b0;
    fsm_capture = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      S_SHIFT:   begin fsm_shift   = 1'b1; busy = 1'b1; end
      S_UPDATE:  begin fsm_update  = 1'b1; busy = 1'b1; end
      S_CAPTURE: begin fsm_capture = 1'b1; busy = 1'b1; end
      S_DONE:    begin done        = 1'b1; busy = 1'b1; end
      default:   ;
    endcase
  end

  assign scan_state = state;

  // ---------------------------------------------------------------------------
  // WIR shift/update stages. Updates while busy are already blocked by
  // strobe_ok, so the instruction cannot change under a running scan.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (reset) begin
      wir_q     <= RST_WIR;
      wir_stage <= '0;
    end else if (SelectWIR) begin
      if (cap_ok)   wir_stage <= WIR_WIDTH'(1);
      if (shift_ok) wir_stage <= {WSI, wir_stage[WIR_WIDTH-1:1]};
      if (upd_ok)   wir_q     <= wir_stage;
    end
  end

  // Bypass register (WR path, WS_BYPASS and unused codes)
  always_ff @(posedge CLK) begin
    if (reset) begin
      bypass_q <= 1'b0;
    end else if (!SelectWIR && is_bypass) begin
      if (shift_ok) bypass_q <= WSI;
      if (cap_ok)   bypass_q <= 1'b0;
    end
  end

  // Registered serial strobe copies for EXTEST/INTEST/SAFE. WP_EXTEST drops
  // serial strobes so the auto-scan engine owns the WBR enables.
  always_ff @(posedge CLK) begin
    if (reset) begin
      ser_capture <= 1'b0;
      ser_shift   <= 1'b0;
      ser_update  <= 1'b0;
    end else begin
      ser_capture <= cap_ok   && !SelectWIR && is_std;
      ser_shift   <= shift_ok && !SelectWIR && is_std;
      ser_update  <= upd_ok   && !SelectWIR && is_std;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) protocol_err <= 1'b0;
    else       protocol_err <= multi_strobe || (busy && any_strobe);
  end

  // ---------------------------------------------------------------------------
  // Registered mode decode (valid the cycle after wir_q changes)
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (reset) begin
      wbr_mode    <= RST_MODE;
      wse_outputs <= RST_MODE;
      is_safe_q   <= RST_MODE;
      is_ext_q    <= 1'b0;
    end else begin
      wbr_mode    <= is_std || is_wp;
      wse_outputs <= (wir_q == I_EXTEST) || (wir_q == I_SAFE) || is_wp;
      is_safe_q   <= (wir_q == I_SAFE);
      is_ext_q    <= (wir_q == I_EXTEST) || is_wp;
    end
  end

  // Serial copies and the FSM never overlap: serial strobes are blocked while
  // busy, and the FSM only runs under WP_EXTEST where serial copies are off.
  assign wbr_capture  = ser_capture || fsm_capture;
  assign wbr_shift    = ser_shift   || fsm_shift;
  assign wbr_update   = ser_update  || fsm_update;
  assign hold_outputs = is_safe_q || (wbr_shift && is_ext_q);

  always_comb begin
    if (SelectWIR)      WSO = wir_stage[0];
    else if (is_bypass) WSO = bypass_q;
    else                WSO = wbr_so;
  end

endmodule

// File: tb/tb_wbr_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_wbr_ctrl -- self-checking bench for wbr_ctrl.
// The reference model tracks the auto-scan as "cycles since run start" and the
// WIR/bypass contents as plain variables updated by the strobe rules.
// -----------------------------------------------------------------------------
module tb_wbr_ctrl;

  localparam int WIR_WIDTH = 3;
  localparam int WBR_LEN   = 21;
  localparam int CNT_W     = 5;

`ifdef WBR_CTRL_SAFE_RESET_EN
  localparam logic [2:0] RST_WIR  = 3'b011;
  localparam logic       RST_MODE = 1'b1;
`else
  localparam logic [2:0] RST_WIR  = 3'b000;
  localparam logic       RST_MODE = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / DUT
  // ---------------------------------------------------------------------------
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       reset = 1'b1, WSI = 1'b0, SelectWIR = 1'b0;
  logic       CaptureWR = 1'b0, ShiftWR = 1'b0, UpdateWR = 1'b0;
  logic       wbr_so = 1'b0, run_req = 1'b0;
  logic       WSO, wse_outputs, hold_outputs, wbr_mode;
  logic       wbr_capture, wbr_shift, wbr_update, busy, done, protocol_err;
  logic [2:0] wir_q;
  logic [2:0] scan_state;

  wbr_ctrl #(.WIR_WIDTH(WIR_WIDTH), .WBR_LEN(WBR_LEN), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .reset(reset), .WSI(WSI), .SelectWIR(SelectWIR),
    .CaptureWR(CaptureWR), .ShiftWR(ShiftWR), .UpdateWR(UpdateWR),
    .wbr_so(wbr_so), .run_req(run_req), .WSO(WSO), .wir_q(wir_q),
    .wse_outputs(wse_outputs), .hold_outputs(hold_outputs), .wbr_mode(wbr_mode),
    .wbr_capture(wbr_capture), .wbr_shift(wbr_shift), .wbr_update(wbr_update),
    .busy(busy), .done(done), .protocol_err(protocol_err), .scan_state(scan_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [2:0] m_wir = RST_WIR, m_stage = 3'b000;
  logic       m_byp = 1'b0;
  int         m_t = 0;  // 0 = idle, 1..WBR_LEN+3 = cycle index within a scan
  logic       m_sc = 0, m_ss = 0, m_su = 0, m_perr = 0;
  logic       m_mode = RST_MODE, m_wse = RST_MODE, m_safe = RST_MODE, m_ext = 0;
  logic       e_wso, e_shift, e_upd, e_cap, e_busy, e_done, e_hold;

  function automatic logic inst_bypass(input logic [2:0] w);
    return (w == 3'd0) || (w > 3'd4);
  endfunction

  task automatic model_edge(input logic r, sel, c, s, u, wsi, run);
    int n;
    logic bsy, ok, std;
    logic [2:0] w;
    n   = int'(c) + int'(s) + int'(u);
    bsy = (m_t != 0);
    w   = m_wir;
    if (r) begin
      m_wir = RST_WIR; m_stage = 3'b000; m_byp = 1'b0; m_t = 0;
      m_sc = 0; m_ss = 0; m_su = 0; m_perr = 0;
      m_mode = RST_MODE; m_wse = RST_MODE; m_safe = RST_MODE; m_ext = 0;
    end else begin
      m_perr = (n > 1) || (bsy && n > 0);
      ok  = (n == 1) && !bsy;
      std = (w == 3'd1) || (w == 3'd2) || (w == 3'd3);
      m_sc = ok && !sel && std && c;
      m_ss = ok && !sel && std && s;
      m_su = ok && !sel && std && u;
      if (ok && sel) begin
        if (c) m_stage = 3'b001;
        if (s) m_stage = {wsi, m_stage[2:1]};
        if (u) m_wir = m_stage;
      end
      if (ok && !sel && inst_bypass(w)) begin
        if (s) m_byp = wsi;
        if (c) m_byp = 1'b0;
      end
      if (m_t != 0)                       m_t = (m_t == WBR_LEN + 3) ? 0 : m_t + 1;
      else if (run && w == 3'b100)        m_t = 1;
      m_mode = (w >= 3'd1) && (w <= 3'd4);
      m_wse  = (w == 3'd1) || (w == 3'd3) || (w == 3'd4);
      m_safe = (w == 3'd3);
      m_ext  = (w == 3'd1) || (w == 3'd4);
    end
  endtask

  task automatic model_outs();
    e_shift = m_ss || (m_t >= 1 && m_t <= WBR_LEN);
    e_upd   = m_su || (m_t == WBR_LEN + 1);
    e_cap   = m_sc || (m_t == WBR_LEN + 2);
    e_done  = (m_t == WBR_LEN + 3);
    e_busy  = (m_t != 0);
    e_hold  = m_safe || (e_shift && m_ext);
    if (SelectWIR)             e_wso = m_stage[0];
    else if (inst_bypass(m_wir)) e_wso = m_byp;
    else                       e_wso = wbr_so;
  endtask

  // ---------------------------------------------------------------------------
  // Driver: apply inputs, clock once, advance model, settle for sampling
  // ---------------------------------------------------------------------------
  task automatic step(input logic r, sel, c, s, u, wsi, run);
    reset = r; SelectWIR = sel; CaptureWR = c; ShiftWR = s; UpdateWR = u;
    WSI = wsi; run_req = run; wbr_so = 1'($urandom_range(0, 1));
    @(posedge CLK);
    model_edge(r, sel, c, s, u, wsi, run);
    #1;
    model_outs();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic load_wir(input logic [2:0] v);
    step(0, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < WIR_WIDTH; i++) step(0, 1, 0, 1, 0, v[i], 0);
    step(0, 1, 0, 0, 1, 0, 0);
    idle();
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (wir_q !== RST_WIR) begin
      n_fail++; $display("FAIL reset_wir: got %b expected %b", wir_q, RST_WIR);
    end
    n_checks++;
    if (WSO !== e_wso) begin
      n_fail++; $display("FAIL reset_wso: got %b expected %b", WSO, e_wso);
    end
    n_checks++;
    if ({busy, done, wbr_capture, wbr_shift, wbr_update, protocol_err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got busy/done/cap/shift/upd/perr=%b expected 000000",
               {busy, done, wbr_capture, wbr_shift, wbr_update, protocol_err});
    end
    n_checks++;
    if ({wbr_mode, wse_outputs, hold_outputs} !== {3{RST_MODE}}) begin
      n_fail++;
      $display("FAIL reset_mode: got mode/wse/hold=%b expected %b",
               {wbr_mode, wse_outputs, hold_outputs}, {3{RST_MODE}});
    end
    idle();
  endtask

  task automatic test_wir_load();
    step(0, 1, 1, 0, 0, 0, 0);
    n_checks++;
    if (WSO !== 1'b1) begin n_fail++; $display("FAIL wir_wso0: got %b expected 1", WSO); end
    step(0, 1, 0, 1, 0, 1, 0);
    n_checks++;
    if (WSO !== 1'b0) begin n_fail++; $display("FAIL wir_wso1: got %b expected 0", WSO); end
    step(0, 1, 0, 1, 0, 0, 0);
    n_checks++;
    if (WSO !== 1'b0) begin n_fail++; $display("FAIL wir_wso2: got %b expected 0", WSO); end
    step(0, 1, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 1, 0, 0);
    n_checks++;
    if (wir_q !== 3'b001) begin n_fail++; $display("FAIL wir_update: got %b expected 001", wir_q); end
    idle();
    n_checks++;
    if ({wbr_mode, wse_outputs} !== 2'b11) begin
      n_fail++; $display("FAIL extest_decode: got mode/wse=%b expected 11", {wbr_mode, wse_outputs});
    end
  endtask

  task automatic test_extest_shift();
    int shifts = 0;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) step(0, 0, 0, 1, 0, 1'($urandom_range(0, 1)), 0);
      else       idle();
      if (wbr_shift) shifts++;
      n_checks++;
      if ({wbr_shift, hold_outputs, WSO} !== {e_shift, e_hold, e_wso}) begin
        n_fail++;
        $display("FAIL extest_shift[%0d]: got shift/hold/wso=%b expected %b", i,
                 {wbr_shift, hold_outputs, WSO}, {e_shift, e_hold, e_wso});
      end
    end
    n_checks++;
    if (shifts != 4) begin n_fail++; $display("FAIL extest_shift_cnt: got %0d expected 4", shifts); end
  endtask

  task automatic test_autoscan();
    int busy_cnt = 0, shift_cnt = 0, upd_cnt = 0, cap_cnt = 0;
    load_wir(3'b100);
    step(0, 0, 0, 0, 0, 0, 1);
    exp_q.push_back(8'(WBR_LEN + 3));
    for (int c = 1; c <= 40; c++) begin
      if (busy) busy_cnt++;
      if (wbr_shift) shift_cnt++;
      if (wbr_update) upd_cnt++;
      if (wbr_capture) cap_cnt++;
      n_checks++;
      if ({busy, wbr_shift, wbr_update, wbr_capture, done} !== {e_busy, e_shift, e_upd, e_cap, e_done}) begin
        n_fail++;
        $display("FAIL autoscan_cycle[%0d]: got busy/sh/up/cap/done=%b expected %b", c,
                 {busy, wbr_shift, wbr_update, wbr_capture, done}, {e_busy, e_shift, e_upd, e_cap, e_done});
      end
      if (done) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL autoscan_done_extra: got done at %0d expected none", c);
        end else if (exp_q[0] != 8'(c)) begin
          n_fail++; $display("FAIL autoscan_latency: got %0d expected %0d", c, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
      end
      if (!busy && c > WBR_LEN + 3) break;
      step(0, 0, 0, 0, 0, 0, (c == 5));
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL autoscan_timeout: got %0d pending done expected 0", exp_q.size());
      exp_q.delete();
    end
    n_checks++;
    if ({busy_cnt, shift_cnt, upd_cnt, cap_cnt} !== {32'd24, 32'd21, 32'd1, 32'd1}) begin
      n_fail++;
      $display("FAIL autoscan_counts: got busy=%0d shift=%0d upd=%0d cap=%0d expected 24 21 1 1",
               busy_cnt, shift_cnt, upd_cnt, cap_cnt);
    end
  endtask

  task automatic test_protocol();
    step(0, 1, 1, 1, 0, 1, 0);
    n_checks++;
    if ({protocol_err, wir_q, WSO} !== {1'b1, 3'b100, e_wso}) begin
      n_fail++;
      $display("FAIL multi_strobe: got perr/wir/wso=%b expected %b",
               {protocol_err, wir_q, WSO}, {1'b1, 3'b100, e_wso});
    end
    idle();
    n_checks++;
    if (protocol_err !== 1'b0) begin n_fail++; $display("FAIL perr_pulse: got 1 expected 0"); end
    step(0, 1, 1, 0, 0, 0, 0);   // stage = 001, differs from wir_q
    step(0, 0, 0, 0, 0, 0, 1);
    idle(); idle();
    step(0, 1, 0, 0, 1, 0, 0);
    n_checks++;
    if ({protocol_err, wir_q} !== {1'b1, 3'b100}) begin
      n_fail++; $display("FAIL busy_update: got perr/wir=%b expected 1100", {protocol_err, wir_q});
    end
    for (int i = 0; i < 30; i++) idle();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_drain: got 1 expected 0"); end
  endtask

  task automatic test_reset_mid_run();
    step(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 9; i++) idle();
    n_checks++;
    if (wbr_shift !== 1'b1) begin n_fail++; $display("FAIL midrun_shift10: got 0 expected 1"); end
    step(1, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if ({busy, wbr_shift, wir_q, hold_outputs} !== {1'b0, 1'b0, RST_WIR, RST_MODE}) begin
      n_fail++;
      $display("FAIL midrun_reset: got busy/shift/wir/hold=%b expected %b",
               {busy, wbr_shift, wir_q, hold_outputs}, {1'b0, 1'b0, RST_WIR, RST_MODE});
    end
    idle();
  endtask

  task automatic test_random();
    logic r, sel, c, s, u, run;
    int k;
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 149) == 0);
      sel = 1'($urandom_range(0, 1));
      k   = $urandom_range(0, 9);
      c = (k == 3); s = (k == 4 || k == 5); u = (k == 6);
      if (k == 7) begin c = 1'($urandom_range(0, 1)); s = 1; u = 1'($urandom_range(0, 1)); end
      run = ($urandom_range(0, 9) == 0);
      step(r, sel, c, s, u, 1'($urandom_range(0, 1)), run);
      n_checks++;
      if ({WSO, wir_q, wse_outputs, hold_outputs, wbr_mode, wbr_capture, wbr_shift,
           wbr_update, busy, done, protocol_err} !==
          {e_wso, m_wir, m_wse, e_hold, m_mode, e_cap, e_shift, e_upd, e_busy, e_done, m_perr}) begin
        n_fail++;
        $display("FAIL random[%0d]: got %b expected %b (wso,wir,wse,hold,mode,cap,sh,up,busy,done,perr)", i,
                 {WSO, wir_q, wse_outputs, hold_outputs, wbr_mode, wbr_capture, wbr_shift,
                  wbr_update, busy, done, protocol_err},
                 {e_wso, m_wir, m_wse, e_hold, m_mode, e_cap, e_shift, e_upd, e_busy, e_done, m_perr});
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_wir_load();
    test_extest_shift();
    test_autoscan();
    test_protocol();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wbr_ctrl.md
Name: wbr_ctrl

Overview:
- IEEE 1500 wrapper serial control (WSC) sequencer with Wrapper Instruction Register (WIR).
- Decodes the active instruction into wbr_mode, wse_outputs and hold_outputs for the WBR chain.
- Drives wbr_capture, wbr_shift and wbr_update, either from the serial WSC strobes or from an internal auto-scan engine (WP_EXTEST).
- Sits between the chip-level 1500 port (WSI/WSO, SelectWIR, CaptureWR, ShiftWR, UpdateWR) and the WBR instances.

Parameters:
- WIR_WIDTH, 3, WIR length in bits.
- WBR_LEN, 21, WBR chain length: number of shift cycles per auto-scan.
- CNT_W, 5, shift counter width; must satisfy 2**CNT_W >= WBR_LEN.

Ports:
- CLK  input  1  single clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- WSI  input  1  serial data in.
- SelectWIR  input  1  1 = WSC targets WIR; 0 = targets the WR selected by the active instruction.
- CaptureWR  input  1  capture strobe.
- ShiftWR  input  1  shift strobe.
- UpdateWR  input  1  update strobe.
- wbr_so  input  1  serial out of the WBR chain.
- run_req  input  1  auto-scan start pulse.
- WSO  output  1  serial data out.
- wir_q  output  WIR_WIDTH  active instruction.
- wse_outputs  output  1  WBR output cells drive test data.
- hold_outputs  output  1  WBR output cells hold their update stage.
- wbr_mode  output  1  1 = WBR in test mode.
- wbr_capture  output  1  WBR capture enable.
- wbr_shift  output  1  WBR shift enable.
- wbr_update  output  1  WBR update enable.
- busy  output  1  auto-scan in progress.
- done  output  1  1-cycle pulse at auto-scan end.
- protocol_err  output  1  1-cycle pulse on an illegal strobe combination.

Behaviour:
- Instruction encoding:
  - 000 WS_BYPASS; 001 WS_EXTEST; 010 WS_INTEST; 011 WS_SAFE; 100 WP_EXTEST.
  - 101–111 decode as WS_BYPASS; wir_q still shows the raw value.
- Reset: wir_q=000, WIR shift stage=000, bypass reg=0. FSM=IDLE, counter=0. All other outputs 0.
- Strobe validity:
  - More than one of CaptureWR/ShiftWR/UpdateWR high in a cycle → no action and protocol_err=1 next cycle.
  - Any strobe while busy=1 → strobe ignored, protocol_err=1.
- WIR path (SelectWIR=1):
  - Capture loads the shift stage with 3'b001.
  - Shift: stage <= {WSI, stage[WIR_WIDTH-1:1]}.
  - Update: wir_q <= stage.
  - No WBR strobes are generated.
- WR path (SelectWIR=0, FSM IDLE):
  - Active instruction WS_BYPASS: Shift loads the bypass reg from WSI; Capture clears it to 0.
  - Active instruction EXTEST, INTEST or SAFE: wbr_capture/wbr_shift/wbr_update = registered copies of the strobes (1-cycle latency).
  - Active instruction WP_EXTEST: serial strobes are ignored.
- Mode decode (registered, valid the cycle after wir_q changes):
  - wbr_mode=1 for EXTEST, INTEST, SAFE and WP_EXTEST.
  - wse_outputs=1 for EXTEST, SAFE and WP_EXTEST.
  - hold_outputs=1 for SAFE, and while wbr_shift=1 under EXTEST/WP_EXTEST.
- WSO (combinational from registers):
  - SelectWIR=1 → WIR stage[0].
  - WS_BYPASS → bypass reg.
  - Otherwise → wbr_so.
- Auto-scan FSM (IDLE, SHIFT, UPDATE, CAPTURE, DONE):
  - IDLE→SHIFT on run_req=1 when wir_q=WP_EXTEST; counter <= WBR_LEN-1.
  - run_req in any other instruction, or while busy, is ignored without error.
  - SHIFT: wbr_shift=1, counter decrements; stays exactly WBR_LEN cycles, leaves when counter=0.
  - UPDATE: wbr_update=1, 1 cycle.
  - CAPTURE: wbr_capture=1, 1 cycle.
  - DONE: done=1, 1 cycle, then IDLE.
  - busy=1 in SHIFT through DONE.
- Total run latency: run_req to done = WBR_LEN+3 cycles.
- reset mid-run: next cycle FSM=IDLE and strobes 0; wir_q returns to its reset value.
- WIR update attempted while busy: rejected, wir_q unchanged.

Optional Feature:
- Macro: WBR_CTRL_SAFE_RESET_EN.
- Defined:
  - Reset value of wir_q is 011 (WS_SAFE).
  - wbr_mode=1, wse_outputs=1, hold_outputs=1 from the first cycle after reset.
- Undefined: reset value 000 (WS_BYPASS) with all mode outputs 0.

Test Plan:
- Reset with reset=1 for 3 cycles → wir_q=000, WSO=bypass reg=0, busy=0, all strobes 0.
- Load EXTEST via SelectWIR=1: Capture, then Shift with WSI=1,0,0, then Update → wir_q=001. Next cycle wbr_mode=1 and wse_outputs=1; WSO during the shifts shows 1,0,0 from the captured 001.
- EXTEST, SelectWIR=0, ShiftWR=1 for 4 cycles → wbr_shift high 4 cycles delayed by 1, hold_outputs=1 during shift, WSO=wbr_so.
- wir_q=100, run_req pulse → busy for 24 cycles:
  - wbr_shift for 21 cycles, then wbr_update for 1, wbr_capture for 1, done for 1.
  - Second run_req mid-run ignored.
- CaptureWR=ShiftWR=1 in the same cycle → protocol_err one pulse, WIR/bypass unchanged. UpdateWR during auto-scan → protocol_err, wir_q stays 100.
- reset asserted at SHIFT cycle 10 → next cycle busy=0, wbr_shift=0, wir_q reset value; with WBR_CTRL_SAFE_RESET_EN defined, wir_q=011 and hold_outputs=1.
